// File: rtl/pkt_seq_pkg.sv
// Shared constants for the receive-side packet sequence checker.
package pkt_seq_pkg;

  // Classification codes reported on chk_code
  localparam logic [3:0] CODE_OK         = 4'd0;
  localparam logic [3:0] CODE_FIRST      = 4'd1;
  localparam logic [3:0] CODE_GAP        = 4'd2;
  localparam logic [3:0] CODE_DUP        = 4'd3;
  localparam logic [3:0] CODE_NEWINT     = 4'd4;
  localparam logic [3:0] CODE_NEWINT_GAP = 4'd5;
  localparam logic [3:0] CODE_INT_SKIP   = 4'd6;
  localparam logic [3:0] CODE_RESYNC     = 4'd7;
  localparam logic [3:0] CODE_BADCH      = 4'd8;

  // Tag layout: {interval number, packet number within interval}
  localparam int INT_MSB = 31;
  localparam int INT_LSB = 16;
  localparam int PKT_MSB = 15;
  localparam int PKT_LSB = 0;

  // Modular differences at or above this are treated as "behind"
  localparam logic [15:0] HALF_RANGE = 16'h8000;

  typedef enum logic {CH_IDLE, CH_TRACK} ch_state_e;

  // Codes that raise the sticky error flag
  function automatic logic is_err_code(input logic [3:0] c);
    return (c == CODE_DUP) || (c == CODE_INT_SKIP) ||
           (c == CODE_RESYNC) || (c == CODE_BADCH);
  endfunction

endpackage

// File: rtl/pkt_seq_chan.sv
// One-channel sequence tracker: reference state, classification of the
// incoming tag, and the channel's three saturating statistics counters.
module pkt_seq_chan
  import pkt_seq_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ev_i,
  input  logic             cnt_clr_i,
  input  logic [31:0]      tag_i,
  output logic [3:0]       code_o,
  output logic [15:0]      lost_o,
  output logic [CNT_W-1:0] ok_cnt_o,
  output logic [CNT_W-1:0] lost_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ch_state_e        state_q;
  logic [15:0]      exp_int_q, exp_int_d;
  logic [15:0]      exp_pkt_q, exp_pkt_d;
  logic [CNT_W-1:0] ok_q, lost_q, err_q;
  logic [CNT_W-1:0] lost_d;
  logic [CNT_W+16:0] lost_sum;

  logic [15:0] t_int, t_pkt, di, dp;
  assign t_int = tag_i[INT_MSB:INT_LSB];
  assign t_pkt = tag_i[PKT_MSB:PKT_LSB];
  assign di    = t_int - exp_int_q;
  assign dp    = t_pkt - exp_pkt_q;

  // Classify the tag and derive the next expected interval/packet
  always_comb begin
    code_o    = CODE_FIRST;
    lost_o    = '0;
    exp_int_d = t_int;
    exp_pkt_d = t_pkt + 16'd1;
    if (state_q == CH_TRACK) begin
      if (di == 16'd0) begin
        exp_int_d = exp_int_q;
        if (dp == 16'd0) begin
          code_o    = CODE_OK;
          exp_pkt_d = exp_pkt_q + 16'd1;
        end else if (dp < HALF_RANGE) begin
          code_o = CODE_GAP;
          lost_o = dp;
        end else begin
          // late/duplicate packet leaves the reference untouched
          code_o    = CODE_DUP;
          exp_pkt_d = exp_pkt_q;
        end
      end else if (di == 16'd1) begin
        exp_int_d = exp_int_q + 16'd1;
        if (t_pkt == 16'd0) begin
          code_o = CODE_NEWINT;
        end else begin
          code_o = CODE_NEWINT_GAP;
          lost_o = t_pkt;
        end
      end else if (di < HALF_RANGE) begin
        code_o = CODE_INT_SKIP;
      end else begin
        code_o = CODE_RESYNC;
      end
    end
  end

  // Lost-packet accumulate, saturating instead of wrapping
  always_comb begin
    lost_sum = {17'd0, lost_q} + {{(CNT_W+1){1'b0}}, lost_o};
    if (lost_sum > {17'd0, CNT_MAX}) lost_d = CNT_MAX;
    else                             lost_d = lost_sum[CNT_W-1:0];
  end

  // Reference state: leaves IDLE on the first event, only reset returns it
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= CH_IDLE;
      exp_int_q <= '0;
      exp_pkt_q <= '0;
    end else if (ev_i) begin
      state_q   <= CH_TRACK;
      exp_int_q <= exp_int_d;
      exp_pkt_q <= exp_pkt_d;
    end
  end

  // Statistics counters; a same-cycle clear discards the event's contribution
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      ok_q   <= '0;
      lost_q <= '0;
      err_q  <= '0;
    end else if (cnt_clr_i) begin
      ok_q   <= '0;
      lost_q <= '0;
      err_q  <= '0;
    end else if (ev_i) begin
      if ((code_o == CODE_OK || code_o == CODE_NEWINT) && ok_q != CNT_MAX)
        ok_q <= ok_q + 1'b1;
      lost_q <= lost_d;
      if ((code_o == CODE_DUP || code_o == CODE_INT_SKIP || code_o == CODE_RESYNC) &&
          err_q != CNT_MAX)
        err_q <= err_q + 1'b1;
    end
  end

  assign ok_cnt_o   = ok_q;
  assign lost_cnt_o = lost_q;
  assign err_cnt_o  = err_q;

endmodule

// File: rtl/packet_seq_checker.sv
// Receive-side tag sequence checker: channel decode, per-channel trackers,
// registered result pulse, sticky error flag and counter read mux.
module packet_seq_checker
  import pkt_seq_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ev,
  input  logic [7:0]       n_ch,
  input  logic [31:0]      tag,
  input  logic             cnt_clr,
  input  logic [7:0]       sel_ch,
  output logic             chk_vld,
  output logic [7:0]       chk_ch,
  output logic [3:0]       chk_code,
  output logic [15:0]      chk_lost,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] lost_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err_flag
);

  logic [NCH-1:0]            ev_hit;
  logic [NCH-1:0][3:0]       code_a;
  logic [NCH-1:0][15:0]      lost_a;
  logic [NCH-1:0][CNT_W-1:0] ok_a, lostc_a, err_a;

  logic [3:0]       sel_code;
  logic [15:0]      sel_lost;
  logic             vld_q;
  logic [7:0]       ch_q;
  logic [3:0]       code_q;
  logic [15:0]      lost_q;
  logic             err_q, err_d;
  logic [CNT_W-1:0] rd_ok_q, rd_lost_q, rd_err_q;
  logic [CNT_W-1:0] rd_ok_d, rd_lost_d, rd_err_d;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign ev_hit[gi] = ev && (n_ch == 8'(gi));

    pkt_seq_chan #(.CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .clr_n      (clr_n),
      .ev_i       (ev_hit[gi]),
      .cnt_clr_i  (cnt_clr),
      .tag_i      (tag),
      .code_o     (code_a[gi]),
      .lost_o     (lost_a[gi]),
      .ok_cnt_o   (ok_a[gi]),
      .lost_cnt_o (lostc_a[gi]),
      .err_cnt_o  (err_a[gi])
    );
  end

  // Pick the addressed channel's classification; no match means BADCH
  always_comb begin
    sel_code = CODE_BADCH;
    sel_lost = '0;
    for (int i = 0; i < NCH; i++) begin
      if (n_ch == 8'(i)) begin
        sel_code = code_a[i];
        sel_lost = lost_a[i];
      end
    end
  end

  // Sticky error flag, cleared only by cnt_clr (which also wins over a new error)
  always_comb begin
    err_d = err_q;
    if (cnt_clr)                          err_d = 1'b0;
    else if (ev && is_err_code(sel_code)) err_d = 1'b1;
  end

  // Counter read mux; out-of-range selects read zero
  always_comb begin
    rd_ok_d   = '0;
    rd_lost_d = '0;
    rd_err_d  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel_ch == 8'(i)) begin
        rd_ok_d   = ok_a[i];
        rd_lost_d = lostc_a[i];
        rd_err_d  = err_a[i];
      end
    end
  end

  // Result pulse one cycle after ev; payload holds between events
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      vld_q  <= 1'b0;
      ch_q   <= '0;
      code_q <= '0;
      lost_q <= '0;
    end else begin
      vld_q <= ev;
      if (ev) begin
        ch_q   <= n_ch;
        code_q <= sel_code;
        lost_q <= sel_lost;
      end
    end
  end

  // Error flag and read-mux registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      err_q     <= 1'b0;
      rd_ok_q   <= '0;
      rd_lost_q <= '0;
      rd_err_q  <= '0;
    end else begin
      err_q     <= err_d;
      rd_ok_q   <= rd_ok_d;
      rd_lost_q <= rd_lost_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign chk_vld  = vld_q;
  assign chk_ch   = ch_q;
  assign chk_code = code_q;
  assign chk_lost = lost_q;
  assign err_flag = err_q;
  assign ok_cnt   = rd_ok_q;
  assign lost_cnt = rd_lost_q;
  assign err_cnt  = rd_err_q;

endmodule

// File: tb/tb_packet_seq_checker.sv
// Bench for packet_seq_checker: directed scenarios plus random traffic,
// checked against a tag-rule reference model kept here.
module tb_packet_seq_checker;

  localparam int NCH = 2;
  localparam int CW  = 8;
  localparam longint CMAX = (64'd1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr_n = 1'b0;
  logic          ev = 1'b0;
  logic [7:0]    n_ch = '0;
  logic [31:0]   tag = '0;
  logic          cnt_clr = 1'b0;
  logic [7:0]    sel_ch = '0;
  logic          chk_vld;
  logic [7:0]    chk_ch;
  logic [3:0]    chk_code;
  logic [15:0]   chk_lost;
  logic [CW-1:0] ok_cnt, lost_cnt, err_cnt;
  logic          err_flag;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit     m_trk [NCH];
  int     m_ei  [NCH];
  int     m_ep  [NCH];
  longint m_ok  [NCH];
  longint m_lost[NCH];
  longint m_err [NCH];
  bit     m_flag;

  packet_seq_checker #(.NCH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .clr_n(clr_n), .ev(ev), .n_ch(n_ch), .tag(tag),
    .cnt_clr(cnt_clr), .sel_ch(sel_ch), .chk_vld(chk_vld), .chk_ch(chk_ch),
    .chk_code(chk_code), .chk_lost(chk_lost), .ok_cnt(ok_cnt),
    .lost_cnt(lost_cnt), .err_cnt(err_cnt), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_trk[i] = 0; m_ei[i] = 0; m_ep[i] = 0;
      m_ok[i] = 0; m_lost[i] = 0; m_err[i] = 0;
    end
    m_flag = 0;
  endtask

  // Apply one tag to the model following the classification rules
  task automatic model_ev(input int ch, input logic [31:0] t, input bit clr,
                          output logic [3:0] c, output logic [15:0] l);
    int ti, tp, di, dp;
    ti = int'(t[31:16]);
    tp = int'(t[15:0]);
    l = 0;
    if (ch >= NCH) c = 8;
    else if (!m_trk[ch]) begin
      c = 1; m_trk[ch] = 1; m_ei[ch] = ti; m_ep[ch] = (tp + 1) % 65536;
    end else begin
      di = (ti - m_ei[ch] + 65536) % 65536;
      dp = (tp - m_ep[ch] + 65536) % 65536;
      if (di == 0) begin
        if (dp == 0) begin c = 0; m_ep[ch] = (m_ep[ch] + 1) % 65536; end
        else if (dp < 32768) begin c = 2; l = 16'(dp); m_ep[ch] = (tp + 1) % 65536; end
        else c = 3;
      end else if (di == 1) begin
        c = (tp == 0) ? 4'd4 : 4'd5;
        l = 16'(tp);
        m_ei[ch] = ti; m_ep[ch] = (tp + 1) % 65536;
      end else begin
        c = (di < 32768) ? 4'd6 : 4'd7;
        m_ei[ch] = ti; m_ep[ch] = (tp + 1) % 65536;
      end
    end
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin m_ok[i] = 0; m_lost[i] = 0; m_err[i] = 0; end
      m_flag = 0;
    end else begin
      if (ch < NCH) begin
        if (c == 0 || c == 4) m_ok[ch] = (m_ok[ch] + 1 > CMAX) ? CMAX : m_ok[ch] + 1;
        m_lost[ch] = (m_lost[ch] + longint'(l) > CMAX) ? CMAX : m_lost[ch] + longint'(l);
        if (c == 3 || c == 6 || c == 7) m_err[ch] = (m_err[ch] + 1 > CMAX) ? CMAX : m_err[ch] + 1;
      end
      if (c == 3 || c == 6 || c == 7 || c == 8) m_flag = 1;
    end
  endtask

  // Drive one ev for one cycle and sample the result #1 after the edge
  task automatic drive(input int ch, input logic [31:0] t, input bit clr,
                       output logic v, output logic [7:0] oc, output logic [3:0] code,
                       output logic [15:0] l, output logic ef);
    ev = 1'b1; n_ch = 8'(ch); tag = t; cnt_clr = clr;
    @(posedge clk); #1;
    ev = 1'b0; cnt_clr = 1'b0;
    v = chk_vld; oc = chk_ch; code = chk_code; l = chk_lost; ef = err_flag;
  endtask

  task automatic read_cnt(input int ch, output logic [CW-1:0] o, output logic [CW-1:0] lo,
                          output logic [CW-1:0] e);
    sel_ch = 8'(ch);
    @(posedge clk); #1;
    o = ok_cnt; lo = lost_cnt; e = err_cnt;
  endtask

  logic [31:0] sc_tag [$];
  int          sc_ch  [$];
  bit          sc_clr [$];

  // Play the queued events back to back, comparing each result with the model
  task automatic test_events(input string name);
    logic v, ef; logic [7:0] oc; logic [3:0] code, ec; logic [15:0] l, el;
    for (int i = 0; i < sc_tag.size(); i++) begin
      drive(sc_ch[i], sc_tag[i], sc_clr[i], v, oc, code, l, ef);
      model_ev(sc_ch[i], sc_tag[i], sc_clr[i], ec, el);
      n_tests++;
      if (v !== 1'b1 || oc !== 8'(sc_ch[i]) || code !== ec || l !== el || ef !== m_flag) begin
        n_fail++;
        $display("FAIL %s[%0d]: got vld=%b ch=%0d code=%0d lost=%0d flag=%b, want vld=1 ch=%0d code=%0d lost=%0d flag=%b",
                 name, i, v, oc, code, l, ef, sc_ch[i], ec, el, m_flag);
      end
    end
    sc_tag.delete(); sc_ch.delete(); sc_clr.delete();
  endtask

  task automatic test_counters(input string name);
    logic [CW-1:0] o, lo, e;
    for (int ch = 0; ch <= NCH; ch++) begin
      read_cnt(ch, o, lo, e);
      n_tests++;
      if (ch < NCH) begin
        if (o !== CW'(m_ok[ch]) || lo !== CW'(m_lost[ch]) || e !== CW'(m_err[ch])) begin
          n_fail++;
          $display("FAIL %s cnt ch%0d: got ok=%0d lost=%0d err=%0d, want ok=%0d lost=%0d err=%0d",
                   name, ch, o, lo, e, m_ok[ch], m_lost[ch], m_err[ch]);
        end
      end else if (o !== '0 || lo !== '0 || e !== '0) begin
        n_fail++;
        $display("FAIL %s cnt sel out of range: got ok=%0d lost=%0d err=%0d, want 0 0 0",
                 name, o, lo, e);
      end
    end
  endtask

  task automatic q(input int ch, input logic [31:0] t, input bit clr);
    sc_ch.push_back(ch); sc_tag.push_back(t); sc_clr.push_back(clr);
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    #12;
    n_tests++;
    if (chk_vld !== 1'b0 || chk_ch !== 8'd0 || chk_code !== 4'd0 || chk_lost !== 16'd0 ||
        ok_cnt !== '0 || lost_cnt !== '0 || err_cnt !== '0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got vld=%b ch=%0d code=%0d lost=%0d ok=%0d lc=%0d ec=%0d flag=%b, want all 0",
               chk_vld, chk_ch, chk_code, chk_lost, ok_cnt, lost_cnt, err_cnt, err_flag);
    end
    clr_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    q(0, 32'h0005_0000, 0); q(0, 32'h0005_0001, 0); q(0, 32'h0005_0002, 0);
    test_events("first_ok");
    test_counters("first_ok");
    q(0, 32'h0005_0007, 0); q(0, 32'h0005_0006, 0);
    test_events("gap_dup");
    test_counters("gap_dup");
  endtask

  task automatic test_interval();
    q(1, 32'h0009_000F, 0); q(1, 32'h000A_0000, 0); q(1, 32'h000B_0003, 0);
    q(1, 32'h000F_0000, 0); q(1, 32'h0002_0000, 0);
    test_events("interval");
    test_counters("interval");
  endtask

  task automatic test_wrap();
    // clear rides on the resync that sets up exp 0xFFFF_FFFF
    q(0, 32'hFFFF_FFFE, 1); q(0, 32'hFFFF_FFFF, 0); q(0, 32'hFFFF_0000, 0);
    q(0, 32'h0000_0000, 0);
    test_events("wrap");
    test_counters("wrap");
  endtask

  task automatic test_back_to_back();
    logic [31:0] t0, t1;
    t0 = {16'(m_ei[0]), 16'(m_ep[0])};
    t1 = {16'(m_ei[1]), 16'(m_ep[1])};
    q(0, t0, 0); q(1, t1, 0); q(0, t0 + 32'd1, 0); q(2, 32'h1234_5678, 0);
    q(0, t0 + 32'd2, 1);
    test_events("b2b");
    test_counters("b2b_clr");
    q(0, t0 + 32'd3, 0);
    test_events("b2b_after_clr");
    test_counters("b2b_after_clr");
    // idle cycle: no pulse, payload held
    @(posedge clk); #1;
    n_tests++;
    if (chk_vld !== 1'b0 || chk_code !== 4'd0 || chk_ch !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got vld=%b code=%0d ch=%0d, want vld=0 code=0 ch=0",
               chk_vld, chk_code, chk_ch);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] t;
    t = {16'(m_ei[0]), 16'(m_ep[0])};
    q(0, t, 1);
    q(0, t + 32'd301, 0);           // gap of 300 packets saturates lost_cnt
    t = t + 32'd302;
    for (int i = 0; i < 260; i++) q(0, t + 32'(i), 0);
    test_events("saturate");
    test_counters("saturate");
  endtask

  task automatic test_random();
    int ch, k, ei, ep;
    logic [31:0] t;
    for (int i = 0; i < 400; i++) begin
      ch = ($urandom_range(0, 15) == 0) ? NCH : int'($urandom_range(0, NCH - 1));
      ei = (ch < NCH) ? m_ei[ch] : 0;
      ep = (ch < NCH) ? m_ep[ch] : 0;
      k = int'($urandom_range(0, 8));
      case (k)
        0, 1, 2: t = {16'(ei), 16'(ep)};
        3:       t = {16'(ei), 16'(ep + int'($urandom_range(1, 500)))};
        4:       t = {16'(ei), 16'(ep - int'($urandom_range(1, 5)))};
        5:       t = {16'(ei + 1), 16'($urandom_range(0, 3))};
        6:       t = {16'(ei + int'($urandom_range(2, 9))), 16'($urandom)};
        7:       t = {16'(ei - int'($urandom_range(1, 9))), 16'($urandom)};
        default: t = $urandom;
      endcase
      q(ch, t, $urandom_range(0, 39) == 0);
    end
    test_events("random");
    test_counters("random");
  endtask

  task automatic test_async_reset();
    logic [CW-1:0] o, lo, e;
    q(0, {16'(m_ei[0]), 16'(m_ep[0])}, 0); q(1, 32'h0001_0001, 0);
    test_events("pre_async");
    read_cnt(0, o, lo, e);
    ev = 1'b1; n_ch = 8'd0; tag = 32'h0000_0000;
    #2 clr_n = 1'b0;
    #1;
    n_tests++;
    if (chk_vld !== 1'b0 || chk_ch !== 8'd0 || chk_code !== 4'd0 || chk_lost !== 16'd0 ||
        ok_cnt !== '0 || lost_cnt !== '0 || err_cnt !== '0 || err_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got vld=%b ch=%0d code=%0d lost=%0d ok=%0d lc=%0d ec=%0d flag=%b, want all 0",
               chk_vld, chk_ch, chk_code, chk_lost, ok_cnt, lost_cnt, err_cnt, err_flag);
    end
    ev = 1'b0;
    #1 clr_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    q(1, 32'h0100_0020, 0); q(0, 32'h0300_0040, 0); q(0, 32'h0300_0041, 0);
    test_events("post_async");
    test_counters("post_async");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_interval();
    test_wrap();
    test_back_to_back();
    test_saturation();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_seq_checker.md
Name: packet_seq_checker

Overview:
- Receive-side counterpart of the transmit packet tagger.
- Takes the 32-bit packet tag {interval number[31:16], packet number within interval[15:0]} from each received packet, per channel.
- Checks sequence continuity and classifies each packet.
- Keeps per-channel statistics counters for the control interface, which reads them through a channel-select mux.

Parameters:
- NCH, 2: number of tracked channels (1..16); n_ch values ≥ NCH are rejected.
- CNT_W, 32: width of the statistics counters; all counters saturate.

Ports:
- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous active-low reset
- ev  in  1  tag-valid strobe, one cycle per received packet
- n_ch  in  8  channel of the tag; sampled with ev
- tag  in  32  packet tag; [31:16] interval number, [15:0] packet number; sampled with ev
- cnt_clr  in  1  synchronous clear of all statistics counters and sticky flags
- sel_ch  in  8  channel selected for the counter read mux
- chk_vld  out  1  one-cycle result pulse
- chk_ch  out  8  channel of the result
- chk_code  out  4  classification code, see Behaviour
- chk_lost  out  16  packets lost as detected by this event
- ok_cnt  out  CNT_W  in-order packet count for sel_ch
- lost_cnt  out  CNT_W  lost-packet total for sel_ch
- err_cnt  out  CNT_W  count of DUP/INT_SKIP/RESYNC events for sel_ch
- err_flag  out  1  sticky: any channel has had an error since the last clear

Behaviour:
- Reset (clr_n=0, asynchronous):
  - All channels go to state IDLE; expected interval and packet registers go to 0.
  - All counters go to 0; err_flag=0.
  - chk_vld=0, chk_ch=0, chk_code=0, chk_lost=0.
- Per-channel state machine, 2 states:
  - IDLE: no reference. The first ev on the channel gives FIRST. Store exp_int=tag[31:16] and exp_pkt=tag[15:0]+1. Go to TRACK.
  - TRACK: compute di = tag[31:16]-exp_int (mod 2^16) and dp = tag[15:0]-exp_pkt (mod 2^16).
    - di=0, dp=0: OK. Set exp_pkt+=1. ok_cnt+1.
    - di=0, dp in 1..0x7FFF: GAP. chk_lost=dp; lost_cnt+=dp. Set exp_pkt=tag[15:0]+1.
    - di=0, dp ≥ 0x8000: DUP (late or duplicate packet). exp_pkt is unchanged. err_cnt+1.
    - di=1, tag[15:0]=0: NEWINT. Set exp_int+=1, exp_pkt=1. ok_cnt+1.
    - di=1, tag[15:0]≠0: NEWINT_GAP. chk_lost=tag[15:0]; lost_cnt+=tag[15:0]. Set exp_int+=1, exp_pkt=tag[15:0]+1.
    - di in 2..0x7FFF: INT_SKIP. chk_lost=0. Reload exp_int/exp_pkt from the tag as for FIRST. err_cnt+1.
    - di ≥ 0x8000: RESYNC (interval went backwards). Reload from the tag. err_cnt+1.
  - The channel stays in TRACK until reset.
- Codes: 0 OK, 1 FIRST, 2 GAP, 3 DUP, 4 NEWINT, 5 NEWINT_GAP, 6 INT_SKIP, 7 RESYNC, 8 BADCH.
- BADCH: ev with n_ch ≥ NCH. Result pulse with code 8. No channel state or counter changes. err_flag is set.
- Latency: ev in cycle N gives chk_vld=1 in cycle N+1, with chk_ch/chk_code/chk_lost valid in the same cycle. Counters are updated in N+1.
- Back-to-back ev on every cycle is supported, including the same channel in consecutive cycles. Use the next-state value; no bubble.
- Wrap-around: exp_pkt 0xFFFF→0x0000 and exp_int 0xFFFF→0x0000 are normal. All comparisons are modular as above.
- Saturation: counters hold at 2^CNT_W-1. lost_cnt addition saturates rather than wrapping.
- err_flag is set in N+1 on any code 3, 6, 7 or 8. It clears only on cnt_clr or reset.
- cnt_clr and ev in the same cycle:
  - Counters and err_flag clear; the event's counter and flag contribution is discarded.
  - Sequence state still updates and the result pulse is still produced.
- cnt_clr does not return channels to IDLE. Only reset does.
- Read mux: registered, one cycle after sel_ch changes. sel_ch ≥ NCH reads 0.
- chk_vld=0 in every cycle without a preceding ev. Other chk_* outputs hold their last value.

Decomposition:
- Package pkt_seq_pkg contains:
  - code constants (CODE_OK … CODE_BADCH, 4-bit)
  - tag field positions INT_MSB=31, INT_LSB=16, PKT_MSB=15, PKT_LSB=0
  - half-range threshold 16'h8000
- Sub-module pkt_seq_chan: one-channel tracker (state, exp_int, exp_pkt, classification, three saturating counters). It is instantiated NCH times by generate.
- The top level handles n_ch decode, the result register, err_flag and the read mux.

Test Plan:
1. Reset, then ch0 tags 0x0005_0000, 0x0005_0001, 0x0005_0002 → codes FIRST, OK, OK; ok_cnt(ch0)=2, lost_cnt=0.
2. ch0 in TRACK, exp 0x0005_0003, tag 0x0005_0007 → GAP, chk_lost=4, lost_cnt=4. Then tag 0x0005_0006 → DUP, err_cnt=1, err_flag=1.
3. ch1 exp 0x0009_0010. Tag 0x000A_0000 → NEWINT. Next tag 0x000B_0003 → NEWINT_GAP, chk_lost=3. Next tag 0x000F_0000 → INT_SKIP. Next tag 0x0002_0000 → RESYNC, err_cnt(ch1)=2.
4. Wrap: ch0 exp 0xFFFF_FFFF, tags 0xFFFF_FFFF, 0xFFFF_0000, 0x0000_0000 → OK, OK, NEWINT; no errors.
5. ev every cycle alternating ch0/ch1/ch0, n_ch=2 once, and cnt_clr asserted with the last ev → results at N+1 each; BADCH for n_ch=2; all counters 0 after the clear, but the next in-order tag is OK.
6. Assert clr_n low mid-stream, asynchronously between edges → outputs go to 0 immediately; after release, the next tag on each channel gives FIRST.
